// File: rtl/tl_rx_cpl_tag_tracker_if.sv
// Bus bundle between the TL TX/RX datapaths and the completion tag tracker.
// The TX/RX side uses the master modport and the tracker uses the slave modport.
// cpl_timeout is only present when CPL_TIMEOUT_EN is defined.
interface tl_rx_cpl_tag_tracker_if #(
  parameter int unsigned REQUESTER_ID_WIDTH  = 16,
  parameter int unsigned REQUESTER_TAG_WIDTH = 10
);

  // Configuration
  logic [REQUESTER_ID_WIDTH-1:0]  own_req_id;

  // TX tag allocation
  logic                           alloc_req;
  logic                           alloc_gnt;
  logic [REQUESTER_TAG_WIDTH-1:0] alloc_tag;
  logic [REQUESTER_TAG_WIDTH-1:0] tx_last_req_tag;
  logic [REQUESTER_ID_WIDTH-1:0]  tx_req_id;

  // RX completion lookup
  logic                           cpl_valid;
  logic [REQUESTER_ID_WIDTH-1:0]  cpl_req_id;
  logic [REQUESTER_TAG_WIDTH-1:0] cpl_tag;
  logic                           cpl_last;
  logic                           cpl_check_en;
  logic                           flush;
  logic                           cpl_hit;
  logic                           cpl_unexpected;

  // Occupancy
  logic [REQUESTER_TAG_WIDTH:0]   outstanding_cnt;
  logic                           full;
  logic                           empty;

`ifdef CPL_TIMEOUT_EN
  logic                           cpl_timeout;
`endif

  modport master (
`ifdef CPL_TIMEOUT_EN
    input  cpl_timeout,
`endif
    output own_req_id, alloc_req, cpl_valid, cpl_req_id, cpl_tag, cpl_last, cpl_check_en,
           flush,
    input  alloc_gnt, alloc_tag, tx_last_req_tag, tx_req_id, cpl_hit, cpl_unexpected,
           outstanding_cnt, full, empty
  );

  modport slave (
`ifdef CPL_TIMEOUT_EN
    output cpl_timeout,
`endif
    input  own_req_id, alloc_req, cpl_valid, cpl_req_id, cpl_tag, cpl_last, cpl_check_en,
           flush,
    output alloc_gnt, alloc_tag, tx_last_req_tag, tx_req_id, cpl_hit, cpl_unexpected,
           outstanding_cnt, full, empty
  );

endinterface

// File: rtl/tl_rx_cpl_tag_tracker.sv
// Outstanding non-posted request scoreboard.
// Hands out tags in strict ring order, marks them pending, retires them on the final
// completion and flags completions that match no pending tag.
// Optional: define CPL_TIMEOUT_EN to add a watchdog that pulses cpl_timeout when
// requests stay outstanding for TIMEOUT_CYCLES cycles without any completion hit.
module tl_rx_cpl_tag_tracker #(
  parameter int unsigned REQUESTER_ID_WIDTH  = 16,
  parameter int unsigned REQUESTER_TAG_WIDTH = 10,
  parameter int unsigned NUM_TAGS            = 256,
  parameter int unsigned TIMEOUT_CYCLES      = 65535
) (
  input logic                     clk,
  input logic                     rst,
  tl_rx_cpl_tag_tracker_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(NUM_TAGS);
  localparam int unsigned TagW = REQUESTER_TAG_WIDTH;
  localparam int unsigned IdW  = REQUESTER_ID_WIDTH;
  localparam int unsigned CntW = REQUESTER_TAG_WIDTH + 1;

  logic [NUM_TAGS-1:0] pend_q, pend_d;
  logic [PtrW-1:0]     alloc_ptr_q, alloc_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [TagW-1:0]     last_tag_q, last_tag_d;
  logic [IdW-1:0]      req_id_q;
  logic                cpl_hit_q, cpl_hit_d;
  logic                cpl_unexp_q, cpl_unexp_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;

  logic                gnt;
  logic                tag_in_range;
  logic [PtrW-1:0]     cpl_idx;
  logic                hit;
  logic                retire;

  // Grant and completion lookup, both against the pre-edge pending bitmap.
  always_comb begin
    gnt          = bus.alloc_req & ~rst & ~bus.flush & ~pend_q[alloc_ptr_q];
    // Tag bits above the tracked range must be zero for the tag to be ours.
    tag_in_range = (bus.cpl_tag >> PtrW) == '0;
    cpl_idx      = bus.cpl_tag[PtrW-1:0];
    hit          = bus.cpl_valid & (bus.cpl_req_id == req_id_q) & tag_in_range &
                   pend_q[cpl_idx];
    retire       = hit & bus.cpl_last;
  end

  // Next-state for bitmap, pointer, occupancy and completion pulses.
  always_comb begin
    pend_d      = pend_q;
    alloc_ptr_d = alloc_ptr_q;
    last_tag_d  = last_tag_q;
    cnt_d       = cnt_q;
    cpl_hit_d   = hit;
    cpl_unexp_d = bus.cpl_valid & ~hit & bus.cpl_check_en;

    if (gnt) begin
      // Pointer wraps naturally because NUM_TAGS is a power of two.
      alloc_ptr_d = alloc_ptr_q + PtrW'(1);
      last_tag_d  = TagW'(alloc_ptr_q);
    end

    if (bus.flush) begin
      pend_d = '0;
      cnt_d  = '0;
    end else begin
      // A granted tag is never pending, so grant and retire never touch the same bit.
      if (gnt)    pend_d[alloc_ptr_q] = 1'b1;
      if (retire) pend_d[cpl_idx]     = 1'b0;
      cnt_d = cnt_q + CntW'(gnt) - CntW'(retire);
    end

    full_d  = (cnt_d == CntW'(NUM_TAGS));
    empty_d = (cnt_d == '0);
  end

  // Tracker state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      alloc_ptr_q <= '0;
      cnt_q       <= '0;
      last_tag_q  <= '0;
      req_id_q    <= '0;
      cpl_hit_q   <= 1'b0;
      cpl_unexp_q <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      pend_q      <= pend_d;
      alloc_ptr_q <= alloc_ptr_d;
      cnt_q       <= cnt_d;
      last_tag_q  <= last_tag_d;
      req_id_q    <= bus.own_req_id;
      cpl_hit_q   <= cpl_hit_d;
      cpl_unexp_q <= cpl_unexp_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
    end
  end

`ifdef CPL_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;

  // Watchdog: idles while nothing is outstanding or progress is being made.
  always_comb begin
    wd_d      = wd_q + 32'd1;
    timeout_d = 1'b0;
    if (bus.flush || hit || empty_q) begin
      wd_d = '0;
    end else if (wd_d == 32'(TIMEOUT_CYCLES)) begin
      wd_d      = '0;
      timeout_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.cpl_timeout = timeout_q;
`endif

  assign bus.alloc_gnt       = gnt;
  assign bus.alloc_tag       = TagW'(alloc_ptr_q);
  assign bus.tx_last_req_tag = last_tag_q;
  assign bus.tx_req_id       = req_id_q;
  assign bus.cpl_hit         = cpl_hit_q;
  assign bus.cpl_unexpected  = cpl_unexp_q;
  assign bus.outstanding_cnt = cnt_q;
  assign bus.full            = full_q;
  assign bus.empty           = empty_q;

  // Sanity checks on configuration and invariants.
  a_cfg: assert property (@(posedge clk)
    (NUM_TAGS >= 2) && ((NUM_TAGS & (NUM_TAGS - 1)) == 0) &&
    (NUM_TAGS <= (1 << TagW)) && (TIMEOUT_CYCLES > 0));
  a_cnt_max: assert property (@(posedge clk) disable iff (rst) cnt_q <= CntW'(NUM_TAGS));
  a_cnt_pop: assert property (@(posedge clk) disable iff (rst)
    cnt_q == CntW'($countones(pend_q)));
  a_excl: assert property (@(posedge clk) !(cpl_hit_q && cpl_unexp_q));

endmodule

// File: tb/tb_tl_rx_cpl_tag_tracker.sv
// Directed bench for tl_rx_cpl_tag_tracker with NUM_TAGS=4, own ID 0x0200.
// Inputs change and combinational outputs are sampled between edges; registered
// outputs are sampled at the falling edge after the rising edge of interest.
module tb_tl_rx_cpl_tag_tracker;

  localparam int unsigned IdW  = 16;
  localparam int unsigned TagW = 10;
  localparam int unsigned NTag = 4;
  localparam logic [15:0] OwnId = 16'h0200;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tl_rx_cpl_tag_tracker_if #(
    .REQUESTER_ID_WIDTH  (IdW),
    .REQUESTER_TAG_WIDTH (TagW)
  ) bus ();

  tl_rx_cpl_tag_tracker #(
    .REQUESTER_ID_WIDTH  (IdW),
    .REQUESTER_TAG_WIDTH (TagW),
    .NUM_TAGS            (NTag),
    .TIMEOUT_CYCLES      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_cpl(input logic v, input logic [15:0] id, input logic [9:0] tag,
                         input logic last, input logic en);
    bus.cpl_valid    = v;
    bus.cpl_req_id   = id;
    bus.cpl_tag      = tag;
    bus.cpl_last     = last;
    bus.cpl_check_en = en;
  endtask

  initial begin
    rst            = 1'b1;
    bus.own_req_id = OwnId;
    bus.alloc_req  = 1'b0;
    bus.flush      = 1'b0;
    set_cpl(1'b0, 16'h0, 10'd0, 1'b0, 1'b0);
    step();
    step();

    // Reset state
    check_eq("rst_cnt", 32'(bus.outstanding_cnt), 0);
    check_eq("rst_empty", 32'(bus.empty), 1);
    check_eq("rst_full", 32'(bus.full), 0);
    check_eq("rst_hit", 32'(bus.cpl_hit), 0);
    check_eq("rst_unexp", 32'(bus.cpl_unexpected), 0);
    check_eq("rst_last_tag", 32'(bus.tx_last_req_tag), 0);
    check_eq("rst_req_id", 32'(bus.tx_req_id), 0);
    rst = 1'b0;
    step();
    check_eq("req_id_copy", 32'(bus.tx_req_id), 32'h0200);

    // Three back-to-back grants: tags 0,1,2
    bus.alloc_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("seq_gnt", 32'(bus.alloc_gnt), 1);
      check_eq("seq_tag", 32'(bus.alloc_tag), 32'(i));
      step();
    end
    bus.alloc_req = 1'b0;
    check_eq("seq_last_tag", 32'(bus.tx_last_req_tag), 2);
    check_eq("seq_cnt", 32'(bus.outstanding_cnt), 3);
    check_eq("seq_empty", 32'(bus.empty), 0);

    // Partial then final completion on tag 1
    set_cpl(1'b1, OwnId, 10'd1, 1'b0, 1'b1);
    step();
    check_eq("part_hit", 32'(bus.cpl_hit), 1);
    check_eq("part_unexp", 32'(bus.cpl_unexpected), 0);
    check_eq("part_cnt", 32'(bus.outstanding_cnt), 3);
    set_cpl(1'b1, OwnId, 10'd1, 1'b1, 1'b1);
    step();
    check_eq("final_hit", 32'(bus.cpl_hit), 1);
    check_eq("final_cnt", 32'(bus.outstanding_cnt), 2);

    // Unexpected completions: retired tag, out-of-range tag, wrong requester ID
    set_cpl(1'b1, OwnId, 10'd1, 1'b1, 1'b1);
    step();
    check_eq("retired_unexp", 32'(bus.cpl_unexpected), 1);
    check_eq("retired_hit", 32'(bus.cpl_hit), 0);
    set_cpl(1'b1, OwnId, 10'd5, 1'b1, 1'b1);
    step();
    check_eq("tag5_unexp", 32'(bus.cpl_unexpected), 1);
    check_eq("tag5_hit", 32'(bus.cpl_hit), 0);
    set_cpl(1'b1, 16'h0100, 10'd0, 1'b1, 1'b1);
    step();
    check_eq("badid_unexp", 32'(bus.cpl_unexpected), 1);
    check_eq("badid_hit", 32'(bus.cpl_hit), 0);
    check_eq("badid_cnt", 32'(bus.outstanding_cnt), 2);
    set_cpl(1'b1, OwnId, 10'd5, 1'b1, 1'b0);
    step();
    check_eq("noen_unexp", 32'(bus.cpl_unexpected), 0);
    check_eq("noen_hit", 32'(bus.cpl_hit), 0);
    set_cpl(1'b0, OwnId, 10'd0, 1'b0, 1'b0);

    // Pending {0,2}, pointer 3: grant 3, then pointer blocks on tag 0 though tag 1 is free
    bus.alloc_req = 1'b1;
    #1;
    check_eq("g3_gnt", 32'(bus.alloc_gnt), 1);
    check_eq("g3_tag", 32'(bus.alloc_tag), 3);
    step();
    check_eq("g3_cnt", 32'(bus.outstanding_cnt), 3);
    #1;
    check_eq("blk0_gnt", 32'(bus.alloc_gnt), 0);
    bus.alloc_req = 1'b0;
    set_cpl(1'b1, OwnId, 10'd0, 1'b1, 1'b1);
    step();
    check_eq("ret0_hit", 32'(bus.cpl_hit), 1);
    check_eq("ret0_cnt", 32'(bus.outstanding_cnt), 2);
    set_cpl(1'b0, OwnId, 10'd0, 1'b0, 1'b0);
    bus.alloc_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("fill_gnt", 32'(bus.alloc_gnt), 1);
      check_eq("fill_tag", 32'(bus.alloc_tag), 32'(i));
      step();
    end
    #1;
    check_eq("full_flag", 32'(bus.full), 1);
    check_eq("full_cnt", 32'(bus.outstanding_cnt), 4);
    check_eq("full_gnt", 32'(bus.alloc_gnt), 0);

    // Retire tag 3: pointer at 2 still blocked
    set_cpl(1'b1, OwnId, 10'd3, 1'b1, 1'b1);
    step();
    #1;
    check_eq("ret3_cnt", 32'(bus.outstanding_cnt), 3);
    check_eq("ret3_full", 32'(bus.full), 0);
    check_eq("ret3_gnt", 32'(bus.alloc_gnt), 0);
    // Retire tag 2: no grant in the retiring cycle
    set_cpl(1'b1, OwnId, 10'd2, 1'b1, 1'b1);
    #1;
    check_eq("ret2_same_gnt", 32'(bus.alloc_gnt), 0);
    step();
    // Grant tag 2 while retiring tag 0 in the same cycle
    set_cpl(1'b1, OwnId, 10'd0, 1'b1, 1'b1);
    #1;
    check_eq("swap_gnt", 32'(bus.alloc_gnt), 1);
    check_eq("swap_tag", 32'(bus.alloc_tag), 2);
    check_eq("swap_cnt_pre", 32'(bus.outstanding_cnt), 2);
    step();
    check_eq("swap_hit", 32'(bus.cpl_hit), 1);
    check_eq("swap_cnt", 32'(bus.outstanding_cnt), 2);
    check_eq("swap_last_tag", 32'(bus.tx_last_req_tag), 2);
    // Completion for the tag granted this same cycle is a miss
    set_cpl(1'b1, OwnId, 10'd3, 1'b1, 1'b1);
    #1;
    check_eq("race_gnt", 32'(bus.alloc_gnt), 1);
    check_eq("race_tag", 32'(bus.alloc_tag), 3);
    step();
    check_eq("race_unexp", 32'(bus.cpl_unexpected), 1);
    check_eq("race_hit", 32'(bus.cpl_hit), 0);
    check_eq("race_cnt", 32'(bus.outstanding_cnt), 3);

    // Flush with tags {1,2,3}; completion on tag 1 during flush still hits
    bus.flush = 1'b1;
    set_cpl(1'b1, OwnId, 10'd1, 1'b0, 1'b1);
    #1;
    check_eq("flush_gnt", 32'(bus.alloc_gnt), 0);
    step();
    bus.flush = 1'b0;
    check_eq("flush_cnt", 32'(bus.outstanding_cnt), 0);
    check_eq("flush_empty", 32'(bus.empty), 1);
    check_eq("flush_hit", 32'(bus.cpl_hit), 1);
    check_eq("flush_last_tag", 32'(bus.tx_last_req_tag), 3);
    // Old tag after flush is unexpected; pointer held at 0
    set_cpl(1'b1, OwnId, 10'd2, 1'b1, 1'b1);
    #1;
    check_eq("post_flush_tag", 32'(bus.alloc_tag), 0);
    check_eq("post_flush_gnt", 32'(bus.alloc_gnt), 1);
    step();
    bus.alloc_req = 1'b0;
    set_cpl(1'b0, OwnId, 10'd0, 1'b0, 1'b0);
    check_eq("post_flush_unexp", 32'(bus.cpl_unexpected), 1);
    check_eq("post_flush_cnt", 32'(bus.outstanding_cnt), 1);

    // Reset mid-operation
    rst           = 1'b1;
    bus.alloc_req = 1'b1;
    #1;
    check_eq("rst_gnt", 32'(bus.alloc_gnt), 0);
    step();
    bus.alloc_req = 1'b0;
    check_eq("rst2_cnt", 32'(bus.outstanding_cnt), 0);
    check_eq("rst2_empty", 32'(bus.empty), 1);
    check_eq("rst2_last_tag", 32'(bus.tx_last_req_tag), 0);
    rst = 1'b0;
    step();

`ifdef CPL_TIMEOUT_EN
    // One tag outstanding, no completions: pulse 16 edges after the grant edge
    bus.alloc_req = 1'b1;
    step();
    bus.alloc_req = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check_eq("to_early", 32'(bus.cpl_timeout), 0);
    step();
    check_eq("to_pulse", 32'(bus.cpl_timeout), 1);
    step();
    check_eq("to_after", 32'(bus.cpl_timeout), 0);
    check_eq("to_cnt", 32'(bus.outstanding_cnt), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_rx_cpl_tag_tracker.md
Name: tl_rx_cpl_tag_tracker

Overview:
- Outstanding non-posted request scoreboard between the TL TX request path and the RX completion error checks.
- Allocates tags to outgoing non-posted requests and records each as outstanding.
- Retires a tag on its final completion, flags completions that match no outstanding request, and drives the last-issued tag and requester ID consumed by the RX unexpected-completion check.

Parameters:
- REQUESTER_ID_WIDTH, 16, width of requester/completer ID.
- REQUESTER_TAG_WIDTH, 10, width of tag field.
- NUM_TAGS, 256, number of tracked tags (power of 2, ≤ 2^REQUESTER_TAG_WIDTH); tags 0..NUM_TAGS-1 are used.
- TIMEOUT_CYCLES, 65535, watchdog limit (used only with CPL_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- own_req_id  in  REQUESTER_ID_WIDTH  this function's requester ID (from config space).
- alloc_req  in  1  TX wants a tag for a non-posted request.
- alloc_gnt  out  1  tag granted this cycle (combinational).
- alloc_tag  out  REQUESTER_TAG_WIDTH  granted tag (valid with alloc_gnt).
- tx_last_req_tag  out  REQUESTER_TAG_WIDTH  most recently granted tag (registered).
- tx_req_id  out  REQUESTER_ID_WIDTH  registered copy of own_req_id.
- cpl_valid  in  1  RX completion header valid.
- cpl_req_id  in  REQUESTER_ID_WIDTH  requester ID field of the completion.
- cpl_tag  in  REQUESTER_TAG_WIDTH  tag field of the completion.
- cpl_last  in  1  final completion for that request (byte count satisfied).
- cpl_check_en  in  1  unexpected-completion reporting enable.
- flush  in  1  drop all outstanding tags (link down / FLR).
- cpl_hit  out  1  pulse: completion matched an outstanding tag.
- cpl_unexpected  out  1  pulse: completion matched no outstanding tag.
- outstanding_cnt  out  REQUESTER_TAG_WIDTH+1  number of outstanding tags.
- full  out  1  outstanding_cnt == NUM_TAGS.
- empty  out  1  outstanding_cnt == 0.

Behaviour:
- State:
  - pend[NUM_TAGS] bitmap.
  - alloc_ptr (log2 NUM_TAGS bits).
  - outstanding_cnt, tx_last_req_tag, tx_req_id.
- Reset (rst=1 at edge):
  - pend=0, alloc_ptr=0, outstanding_cnt=0, tx_last_req_tag=0, tx_req_id=0.
  - cpl_hit=0, cpl_unexpected=0, full=0, empty=1.
  - A reset mid-operation discards all state; there is no partial state.
- Allocation:
  - alloc_gnt = alloc_req & ~rst & ~flush & ~pend[alloc_ptr].
  - alloc_tag = alloc_ptr, zero-extended.
  - On grant: pend[alloc_ptr] set next edge, alloc_ptr increments and wraps NUM_TAGS-1 → 0, tx_last_req_tag <= alloc_tag.
  - If pend[alloc_ptr]=1 (in-order pointer blocked), there is no grant and the pointer holds; the request stalls until that tag retires, even if other tags are free.
- Completion lookup:
  - Uses pre-edge pend.
  - hit = cpl_valid & (cpl_req_id == tx_req_id) & (cpl_tag < NUM_TAGS) & pend[cpl_tag].
  - Next edge: cpl_hit <= hit; cpl_unexpected <= cpl_valid & ~hit & cpl_check_en.
  - Latency is 1 cycle. Both outputs are single-cycle pulses and are never both 1.
- Retire:
  - hit & cpl_last clears pend[cpl_tag] next edge.
  - hit & ~cpl_last leaves the tag pending (partial completion).
- Simultaneous events:
  - Grant and retire in the same cycle: outstanding_cnt is unchanged, both bitmap updates are applied, and the tags are necessarily different.
  - A completion for the tag being granted in the same cycle is a miss (unexpected).
  - A tag retired this cycle is grantable from the next cycle.
- flush:
  - Next edge: pend=0, outstanding_cnt=0.
  - alloc_ptr and tx_last_req_tag hold.
  - No grant during flush.
  - A completion during flush is still evaluated against pre-edge pend.
- Counter:
  - outstanding_cnt += grant − retire.
  - Saturation cannot occur by construction; an assertion checks it never exceeds NUM_TAGS.
- full/empty are registered, consistent with outstanding_cnt.

Optional Feature:
- CPL_TIMEOUT_EN defined:
  - Adds output cpl_timeout (1-bit pulse) and a 32-bit watchdog counter.
  - The counter clears on reset, flush, any hit, or empty=1; otherwise it increments each cycle.
  - On reaching TIMEOUT_CYCLES: cpl_timeout pulses for 1 cycle and the counter restarts at 0. Pend is not modified.
- Not defined:
  - No cpl_timeout port and no counter logic.

Test Plan:
- Reset, then alloc_req held 3 cycles -> alloc_tag 0,1,2 each with alloc_gnt=1; tx_last_req_tag=2 and outstanding_cnt=3 after the third edge.
- Tag 1 outstanding, cpl_valid with tag 1, own ID, cpl_last=0, then again with cpl_last=1 -> cpl_hit on both following cycles; tag 1 cleared only after the second; outstanding_cnt 3→2.
- cpl_check_en=1, completion tag 5 (not pending) or wrong req_id 0x0100 vs own 0x0200 -> cpl_unexpected=1 one cycle later, cpl_hit=0; same stimulus with cpl_check_en=0 -> both 0.
- NUM_TAGS=4, fill all 4 -> full=1, alloc_gnt=0. Retire tag 2 -> still no grant (alloc_ptr=0 pending). Retire tag 0 -> grant tag 0 next request.
- Grant and retire different tags in the same cycle -> outstanding_cnt unchanged. Completion for the tag being granted that cycle -> cpl_unexpected.
- flush with 3 outstanding -> empty=1 and count 0 next cycle; a subsequent completion for an old tag -> cpl_unexpected. With CPL_TIMEOUT_EN and TIMEOUT_CYCLES=16, one tag outstanding and no completions -> cpl_timeout pulse at cycle 16.
